// File: rtl/riscv_pkg.sv
// Shared RV32 decode types: control bundle, bubble constant, encodings.
// Used by the decode control unit and the ID/EX pipeline register.
package riscv_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic       MemWrite;
    logic       Jump;
    logic       Branch;
    logic [2:0] ALUControl;
    logic       ALUSrc;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Architectural side effects are dropped for an empty slot.
  function automatic ctrl_t ctrl_gate(ctrl_t c, logic v);
    ctrl_t g;
    g = c;
    if (!v) begin
      g.RegWrite = CTRL_NOP.RegWrite;
      g.MemWrite = CTRL_NOP.MemWrite;
      g.Jump     = CTRL_NOP.Jump;
      g.Branch   = CTRL_NOP.Branch;
    end
    return g;
  endfunction

endpackage

// File: rtl/flopenrc.sv
// Flop with enable, synchronous clear and synchronous active-low reset.
// Priority: reset, clear, enable.
module flopenrc #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall, flush-to-bubble and a
// saturating count of inserted bubbles.
module id_ex_reg
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            ValidD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ResultSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic [2:0]      Funct3D,
  input  logic            Funct7b5D,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  output logic            ValidE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [2:0]      Funct3E,
  output logic            Funct7b5E,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [CNT_W-1:0] FlushCountE
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_g;
  logic  en;
  logic  clr;

  assign en  = ~StallE;
  assign clr = FlushE;

  always_comb begin
    ctrl_d            = CTRL_NOP;
    ctrl_d.RegWrite   = RegWriteD;
    ctrl_d.ResultSrc  = ResultSrcD;
    ctrl_d.MemWrite   = MemWriteD;
    ctrl_d.Jump       = JumpD;
    ctrl_d.Branch     = BranchD;
    ctrl_d.ALUControl = ALUControlD;
    ctrl_d.ALUSrc     = ALUSrcD;
  end

  assign ctrl_g = ctrl_gate(ctrl_d, ValidD);

  flopenrc #(1) u_valid (
    .clk, .rst_n, .en, .clr,
    .d(ValidD), .q(ValidE));
  flopenrc #(1) u_rw (
    .clk, .rst_n, .en, .clr,
    .d(ctrl_g.RegWrite), .q(RegWriteE));
  flopenrc #(1) u_mw (
    .clk, .rst_n, .en, .clr,
    .d(ctrl_g.MemWrite), .q(MemWriteE));
  flopenrc #(1) u_jmp (
    .clk, .rst_n, .en, .clr,
    .d(ctrl_g.Jump), .q(JumpE));
  flopenrc #(1) u_br (
    .clk, .rst_n, .en, .clr,
    .d(ctrl_g.Branch), .q(BranchE));
  flopenrc #(1) u_asrc (
    .clk, .rst_n, .en, .clr,
    .d(ctrl_g.ALUSrc), .q(ALUSrcE));
  flopenrc #(2) u_rsrc (
    .clk, .rst_n, .en, .clr,
    .d(ctrl_g.ResultSrc), .q(ResultSrcE));
  flopenrc #(3) u_aluc (
    .clk, .rst_n, .en, .clr,
    .d(ctrl_g.ALUControl), .q(ALUControlE));
  flopenrc #(3) u_f3 (
    .clk, .rst_n, .en, .clr,
    .d(Funct3D), .q(Funct3E));
  flopenrc #(1) u_f7 (
    .clk, .rst_n, .en, .clr,
    .d(Funct7b5D), .q(Funct7b5E));

  flopenrc #(XLEN) u_rd1 (
    .clk, .rst_n, .en, .clr,
    .d(RD1D), .q(RD1E));
  flopenrc #(XLEN) u_rd2 (
    .clk, .rst_n, .en, .clr,
    .d(RD2D), .q(RD2E));
  flopenrc #(XLEN) u_pc (
    .clk, .rst_n, .en, .clr,
    .d(PCD), .q(PCE));
  flopenrc #(XLEN) u_imm (
    .clk, .rst_n, .en, .clr,
    .d(ImmExtD), .q(ImmExtE));
  flopenrc #(XLEN) u_pc4 (
    .clk, .rst_n, .en, .clr,
    .d(PCPlus4D), .q(PCPlus4E));

  flopenrc #(5) u_rs1 (
    .clk, .rst_n, .en, .clr,
    .d(Rs1D), .q(Rs1E));
  flopenrc #(5) u_rs2 (
    .clk, .rst_n, .en, .clr,
    .d(Rs2D), .q(Rs2E));
  flopenrc #(5) u_rd (
    .clk, .rst_n, .en, .clr,
    .d(RdD), .q(RdE));

  // Counts flushes even while stalled; parks at all-ones.
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_en;

  assign cnt_nxt = FlushCountE + CNT_W'(1);
  assign cnt_en  = FlushE & ~(&FlushCountE);

  flopenrc #(CNT_W) u_fcnt (
    .clk, .rst_n,
    .en(cnt_en), .clr(1'b0),
    .d(cnt_nxt), .q(FlushCountE));

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized bench for id_ex_reg against a slot-level reference model,
// plus directed scenarios for stall, flush, invalid slot, reset, saturation.
module tb_id_ex_reg;

  typedef struct packed {
    logic        v;
    logic        rw;
    logic        mw;
    logic        j;
    logic        b;
    logic        as;
    logic [1:0]  rs;
    logic [2:0]  alu;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } slot_t;

  logic clk = 1'b0;
  logic rst_n;
  logic StallE;
  logic FlushE;
  slot_t din;
  slot_t got;
  logic [7:0] FlushCountE;

  logic ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0] ResultSrcE;
  logic [2:0] ALUControlE, Funct3E;
  logic Funct7b5E;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0] Rs1E, Rs2E, RdE;

  always #5 clk = ~clk;

  id_ex_reg #(.XLEN(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .StallE(StallE), .FlushE(FlushE),
    .ValidD(din.v), .RegWriteD(din.rw),
    .MemWriteD(din.mw), .JumpD(din.j),
    .BranchD(din.b), .ALUSrcD(din.as),
    .ResultSrcD(din.rs), .ALUControlD(din.alu),
    .Funct3D(din.f3), .Funct7b5D(din.f7),
    .RD1D(din.rd1), .RD2D(din.rd2),
    .PCD(din.pc), .ImmExtD(din.imm),
    .PCPlus4D(din.pc4),
    .Rs1D(din.rs1), .Rs2D(din.rs2), .RdD(din.rd),
    .ValidE(ValidE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .Funct3E(Funct3E), .Funct7b5E(Funct7b5E),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
    .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .FlushCountE(FlushCountE)
  );

  assign got = '{v: ValidE, rw: RegWriteE, mw: MemWriteE,
                 j: JumpE, b: BranchE, as: ALUSrcE,
                 rs: ResultSrcE, alu: ALUControlE,
                 f3: Funct3E, f7: Funct7b5E,
                 rd1: RD1E, rd2: RD2E, pc: PCE,
                 imm: ImmExtE, pc4: PCPlus4E,
                 rs1: Rs1E, rs2: Rs2E, rd: RdE};

  int nvec = 0;
  int nbad = 0;

  slot_t exp_s;
  int    exp_cnt;
  localparam int CNT_MAX = 255;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] want);
    nvec++;
    if (obs !== want) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  // Reference: what the execute slot should hold after one edge.
  task automatic model_edge();
    if (!rst_n) begin
      exp_s   = '0;
      exp_cnt = 0;
    end else if (FlushE) begin
      exp_s   = '0;
      exp_cnt = (exp_cnt < CNT_MAX) ? exp_cnt + 1 : CNT_MAX;
    end else if (!StallE) begin
      exp_s = din;
      if (!din.v) begin
        exp_s.rw = 1'b0;
        exp_s.mw = 1'b0;
        exp_s.j  = 1'b0;
        exp_s.b  = 1'b0;
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk(tag, 256'({got, FlushCountE}),
        256'({exp_s, 8'(exp_cnt)}));
    chk({tag, "-inv"},
        256'((RegWriteE | MemWriteE) & ~ValidE), 256'(0));
  endtask

  task automatic rand_din();
    logic [223:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom()};
    din = r[$bits(slot_t)-1:0];
  endtask

  initial begin
    rst_n  = 1'b0;
    StallE = 1'b0;
    FlushE = 1'b0;
    exp_s  = '0;
    exp_cnt = 0;
    rand_din();
    step("reset0");
    StallE = 1'b1;
    FlushE = 1'b1;
    step("reset1");
    chk("rst_cnt", 256'(FlushCountE), 256'(0));
    chk("rst_valid", 256'(ValidE), 256'(0));

    // addi x5, imm 0x10
    rst_n = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    din = '0;
    din.v = 1; din.rw = 1; din.as = 1;
    din.alu = 3'b000; din.rd = 5; din.imm = 32'h10;
    din.rd1 = 32'h1234;
    step("addi");
    chk("addi_rw", 256'(RegWriteE), 256'(1));
    chk("addi_rd", 256'(RdE), 256'(5));
    chk("addi_imm", 256'(ImmExtE), 256'(32'h10));
    chk("addi_v", 256'(ValidE), 256'(1));

    // lw then 3-cycle stall while decode shows sw
    din = '0;
    din.v = 1; din.rw = 1; din.rs = 2'b01; din.as = 1;
    din.rd = 7; din.imm = 32'h40; din.rs1 = 2;
    step("lw");
    StallE = 1'b1;
    din = '0;
    din.v = 1; din.mw = 1; din.as = 1;
    din.rs1 = 3; din.rs2 = 4; din.imm = 32'h80;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall_rsrc", 256'(ResultSrcE), 256'(2'b01));
      chk("stall_rd", 256'(RdE), 256'(7));
    end
    StallE = 1'b0;
    step("sw");
    chk("sw_mw", 256'(MemWriteE), 256'(1));
    chk("sw_imm", 256'(ImmExtE), 256'(32'h80));

    // flush beats stall while sw is held
    StallE = 1'b1;
    FlushE = 1'b1;
    step("flush_stall");
    chk("fs_mw", 256'(MemWriteE), 256'(0));
    chk("fs_slot", 256'(got), 256'(0));
    chk("fs_cnt", 256'(FlushCountE), 256'(1));

    // invalid decode slot
    StallE = 1'b0; FlushE = 1'b0;
    din = '0;
    din.v = 0; din.rw = 1; din.mw = 1; din.rd1 = 32'hDEADBEEF;
    step("invalid");
    chk("inv_rw", 256'(RegWriteE), 256'(0));
    chk("inv_mw", 256'(MemWriteE), 256'(0));
    chk("inv_rd1", 256'(RD1E), 256'(32'hDEADBEEF));

    // jal held, then reset with flush
    din = '0;
    din.v = 1; din.j = 1; din.rw = 1; din.rs = 2'b10;
    din.rd = 1; din.pc = 32'h100; din.pc4 = 32'h104;
    step("jal");
    chk("jal_j", 256'(JumpE), 256'(1));
    rst_n = 1'b0; FlushE = 1'b1;
    step("jal_rst");
    chk("jr_j", 256'(JumpE), 256'(0));
    chk("jr_rsrc", 256'(ResultSrcE), 256'(0));
    chk("jr_cnt", 256'(FlushCountE), 256'(0));
    rst_n = 1'b1; FlushE = 1'b0;
    din.pc = 32'h200;
    step("post_rst");
    chk("pr_pc", 256'(PCE), 256'(32'h200));

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rand_din();
      rst_n  = ($urandom_range(0, 49) != 0);
      FlushE = ($urandom_range(0, 6) == 0);
      StallE = ($urandom_range(0, 3) == 0);
      step("rand");
    end

    // saturation
    rst_n = 1'b0;
    step("sat_rst");
    rst_n = 1'b1;
    FlushE = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rand_din();
      StallE = $urandom_range(0, 1) != 0;
      step("sat");
      if (i == 254)
        chk("sat_255", 256'(FlushCountE), 256'(255));
    end
    chk("sat_hold", 256'(FlushCountE), 256'(255));

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL expose parameter XLEN, default 32, datapath word width.
REQ-002 SHALL expose parameter CNT_W, default 8, flush-counter width.
REQ-003 SHALL provide ports, one per line (name  direction  width  meaning):
  clk  in  1  single clock; all state updates on rising edge
  rst_n  in  1  synchronous, active-low reset
  StallE  in  1  hold all stage contents
  FlushE  in  1  replace next contents with a bubble
  ValidD  in  1  decode slot holds a real instruction
  RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decoded control
  ResultSrcD  in  2  result mux select
  ALUControlD  in  3  ALU operation code
  Funct3D  in  3  branch-type / shift-type qualifier
  Funct7b5D  in  1  instr[30]: sub/sra qualifier
  RD1D, RD2D, PCD, ImmExtD, PCPlus4D  in  XLEN each  register data, PC, extended immediate, PC+4
  Rs1D, Rs2D, RdD  in  5 each  register indices
  (all D inputs mirrored as E outputs, same widths)  out
  ValidE  out  1  execute slot holds a real instruction
  FlushCountE  out  CNT_W  saturating count of bubbles inserted by FlushE

Function
REQ-004 SHALL register every D input into its E output with exactly one cycle latency when rst_n=1, FlushE=0, StallE=0.
REQ-005 SHALL, when FlushE=1 (rst_n=1), load a bubble next edge: ValidE=0, RegWriteE=MemWriteE=JumpE=BranchE=ALUSrcE=0, ResultSrcE=00, ALUControlE=000, Funct3E=000, Funct7b5E=0, all data/PC/immediate fields 0, Rs1E=Rs2E=RdE=0.
REQ-006 SHALL, when StallE=1 and FlushE=0, hold every E output unchanged.
REQ-007 SHALL apply priority rst_n=0 > FlushE > StallE > normal load.
REQ-008 SHALL, when ValidD=0 on a normal load, force RegWriteE=MemWriteE=JumpE=BranchE=0 and ValidE=0; data fields still load.
REQ-009 SHALL never assert RegWriteE or MemWriteE when ValidE=0.
REQ-010 SHALL increment FlushCountE by 1 on each edge with FlushE=1 and rst_n=1, regardless of StallE.
REQ-011 SHALL saturate FlushCountE at 2^CNT_W-1; no wrap to 0.
REQ-012 SHALL contain no combinational path from any input to any output.
REQ-013 SHALL treat Funct3D and Funct7b5D as opaque; no decoding inside this block.

Reset
REQ-014 SHALL, on any edge with rst_n=0, drive all E outputs to the bubble values of REQ-005 and FlushCountE to 0.
REQ-015 SHALL let reset override simultaneous FlushE/StallE; the first edge after rst_n returns high performs a normal load, flush, or stall.

Structure
REQ-016 SHALL take the control-bundle typedef (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc), the bubble constant CTRL_NOP, and the ResultSrc/ALUControl encodings from shared package riscv_pkg, as used by the decode control unit.
REQ-017 SHALL build each field from one parameterised sub-module flopenrc (width W, enable, synchronous clear, synchronous active-low reset).

Verification
REQ-018 Normal load: addi decode (RegWriteD=1, ALUSrcD=1, ALUControlD=000, RdD=5, ImmExtD=0x00000010, ValidD=1), StallE=FlushE=0 -> next cycle RegWriteE=1, RdE=5, ImmExtE=0x00000010, ValidE=1.
REQ-019 Stall: load lw (ResultSrcD=01), then StallE=1 for 3 cycles while D inputs change to sw -> E outputs stay lw values for 3 cycles; sw appears one cycle after StallE drops.
REQ-020 Flush vs stall: FlushE=1 and StallE=1 on same edge while holding a sw (MemWriteE=1) -> next cycle MemWriteE=0, ValidE=0, all fields 0, FlushCountE +1.
REQ-021 Invalid slot: ValidD=0 with RegWriteD=1, MemWriteD=1, RD1D=0xDEADBEEF -> RegWriteE=0, MemWriteE=0, ValidE=0, RD1E=0xDEADBEEF.
REQ-022 Counter saturation: CNT_W=8, FlushE=1 for 300 cycles -> FlushCountE reaches 255 and holds 255.
REQ-023 Reset mid-operation: rst_n=0 for one edge with FlushE=1 and a valid jal held (JumpE=1, ResultSrcE=10) -> JumpE=0, ResultSrcE=00, ValidE=0, FlushCountE=0; next edge with rst_n=1 loads D inputs normally.
